redas_skew_feeder: RTL

//  Upstream stage of the REDAS PE array. Accepts row vectors over a valid/ready handshake.

---
 rtl/redas_pkg.sv | 15 +
 rtl/redas_lane_delay.sv | 48 ++++
 rtl/redas_skew_feeder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/redas_pkg.sv
// Shared types and sizing helpers for the REDAS skew feeder slice.
package redas_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM,
    DRAIN
  } feeder_state_t;

  function automatic int drain_cnt_w(input int num_lanes);
    return $clog2(num_lanes) + 1;
  endfunction

endpackage

// File: rtl/redas_lane_delay.sv
// DEPTH-stage shift register of {valid, data}; DEPTH=0 degenerates to a wire.
module redas_lane_delay
  import redas_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  busy_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign valid_o        = valid_i;
    assign data_o         = data_i;
    assign busy_o         = 1'b0;
  end else begin : g_shift
    logic [DEPTH-1:0]      valid_q;
    logic [DATA_WIDTH-1:0] data_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= '0;
        for (int unsigned s = 0; s < DEPTH; s++) begin
          data_q[s] <= '0;
        end
      end else begin
        valid_q[0] <= valid_i;
        data_q[0]  <= data_i;
        for (int unsigned s = 1; s < DEPTH; s++) begin
          valid_q[s] <= valid_q[s-1];
          data_q[s]  <= data_q[s-1];
        end
      end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];
    assign busy_o  = |valid_q;
  end

endmodule

// File: rtl/redas_skew_feeder.sv
// Top-edge feeder for the REDAS PE array: unskewed weight loads with a stationary
// strobe, diagonally skewed activation rows, and a drain phase before returning idle.
module redas_skew_feeder
  import redas_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LANES  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] in_data,
  input  logic                            in_is_weight,
  input  logic                            in_last,
  output logic [NUM_LANES*DATA_WIDTH-1:0] out_data,
  output logic [NUM_LANES-1:0]            out_lane_valid,
  output logic                            out_store_stationary,
  output logic                            busy
);

  localparam int ROW_W = NUM_LANES * DATA_WIDTH;
  localparam int CNT_W = drain_cnt_w(NUM_LANES);
  localparam bit HAS_DRAIN = (NUM_LANES > 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((NUM_LANES > 1) ? NUM_LANES - 2 : 0);

  feeder_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  logic [ROW_W-1:0] cap_data_q;
  logic             cap_act_q, cap_wt_q;
  logic [ROW_W-1:0] stg_data_q;
  logic             stg_act_q, stg_wt_q;

  logic [ROW_W-1:0]     skew_data;
  logic [NUM_LANES-1:0] lane_valid;
  logic [NUM_LANES-1:0] lane_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
    unique case (state_q)
      IDLE:    in_ready = 1'b1;
      LOAD:    in_ready = in_is_weight;
      STREAM:  in_ready = !in_is_weight;
      DRAIN:   in_ready = 1'b0;
      default: in_ready = 1'b0;
    endcase
    accept = in_valid && in_ready;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_is_weight) begin
            if (!in_last) state_d = LOAD;
          end else if (!in_last) begin
            state_d = STREAM;
          end else if (HAS_DRAIN) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end
        end
      end
      LOAD: begin
        if (accept && in_last) state_d = IDLE;
      end
      STREAM: begin
        if (accept && in_last) begin
          state_d = HAS_DRAIN ? DRAIN : IDLE;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        if (cnt_q == DRAIN_LAST) state_d = IDLE;
        else                     cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture then a common stage register; idle cycles load zeros so they travel as bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_data_q <= '0;
      cap_act_q  <= 1'b0;
      cap_wt_q   <= 1'b0;
      stg_data_q <= '0;
      stg_act_q  <= 1'b0;
      stg_wt_q   <= 1'b0;
    end else begin
      cap_data_q <= accept ? in_data : '0;
      cap_act_q  <= accept && !in_is_weight;
      cap_wt_q   <= accept && in_is_weight;
      stg_data_q <= cap_data_q;
      stg_act_q  <= cap_act_q;
      stg_wt_q   <= cap_wt_q;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] lane_in;
    assign lane_in = stg_act_q ? stg_data_q[i*DATA_WIDTH +: DATA_WIDTH] : '0;

    redas_lane_delay #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (i)
    ) u_delay (
      .clk    (clk),
      .rst    (rst),
      .valid_i(stg_act_q),
      .data_i (lane_in),
      .valid_o(lane_valid[i]),
      .data_o (skew_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .busy_o (lane_busy[i])
    );
  end

  assign out_data             = stg_wt_q ? stg_data_q : skew_data;
  assign out_lane_valid       = lane_valid;
  assign out_store_stationary = stg_wt_q;
  assign busy                 = (state_q != IDLE) || cap_act_q || stg_act_q || (|lane_busy);

endmodule
